// File: rtl/rr_arb_mux_4to1.sv
// Round-robin 4:1 arbiter/mux with a one-entry registered output stage (valid/ready).
// Optional burst mode via ARB_BURST_EN: a winner keeps priority for up to MAX_BURST grants.
module rr_arb_mux_4to1 #(
  parameter int N         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  input  logic [4*N-1:0] req_data,
  output logic [3:0]     req_ready,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic [1:0]     out_src,
  input  logic           out_ready
);

  if (MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_max_burst
    $error("rr_arb_mux_4to1: MAX_BURST must be in 1..16");
  end

  logic [1:0]   ptr_r;
  logic [1:0]   ptr_nxt_s;
  logic         load_s;
  logic         any_s;
  logic [1:0]   win_s;
  logic [1:0]   idx_s;
  logic         grant_s;
  logic [N-1:0] mux_s;

`ifdef ARB_BURST_EN
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic [4:0] run_s;
`endif

  assign load_s  = !out_valid || out_ready;
  assign grant_s = load_s && any_s;

  // Scan from the priority pointer; the first valid requester wins.
  always_comb begin
    any_s = 1'b0;
    win_s = 2'd0;
    idx_s = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr_r + 2'(k);
      if (!any_s && req_valid[idx_s]) begin
        any_s = 1'b1;
        win_s = idx_s;
      end else begin
        any_s = any_s;
      end
    end
  end

  // One-hot grant; forced low while reset is held.
  always_comb begin
    req_ready = 4'b0000;
    if (grant_s && !rst) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Data mux: select index i routes requester i's slice.
  always_comb begin
    case (win_s)
      2'd0:    mux_s = req_data[0*N +: N];
      2'd1:    mux_s = req_data[1*N +: N];
      2'd2:    mux_s = req_data[2*N +: N];
      2'd3:    mux_s = req_data[3*N +: N];
      default: mux_s = req_data[0*N +: N];
    endcase
  end

`ifdef ARB_BURST_EN
  // A fresh winner starts a new run; the run ends when it reaches MAX_BURST.
  always_comb begin
    run_s = (win_s == ptr_r) ? ({1'b0, cnt_r} + 5'd1) : 5'd1;
    if (run_s >= 5'(MAX_BURST)) begin
      ptr_nxt_s = win_s + 2'd1;
      cnt_nxt_s = 4'd0;
    end else begin
      ptr_nxt_s = win_s;
      cnt_nxt_s = run_s[3:0];
    end
  end

  // Burst counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 4'd0;
    end else if (grant_s) begin
      cnt_r <= cnt_nxt_s;
    end
  end
`else
  // Plain round-robin: priority moves just past the last winner.
  always_comb begin
    ptr_nxt_s = win_s + 2'd1;
  end
`endif

  // Output register and priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr_r     <= 2'd0;
    end else if (load_s) begin
      if (any_s) begin
        out_valid <= 1'b1;
        out_data  <= mux_s;
        out_src   <= win_s;
        ptr_r     <= ptr_nxt_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_4to1.sv
// Scoreboard bench for rr_arb_mux_4to1: a driver feeds a queue from a reference model,
// a monitor pops and compares each word the DUT presents.
module tb_rr_arb_mux_4to1;
  localparam int N  = 8;
  localparam int MB = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req_valid;
  logic [4*N-1:0] req_data;
  logic [3:0]     req_ready;
  logic           out_valid;
  logic [N-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  typedef struct packed {
    logic [N-1:0] data;
    logic [1:0]   src;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_start  = 0;
  int   m_run    = 0;
  bit   m_valid  = 1'b0;

  rr_arb_mux_4to1 #(.N(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model decides the grant from the arbitration rules.
  task automatic run_cycle(input logic [3:0] v, input logic [4*N-1:0] d, input logic r);
    int   w;
    int   idx;
    bit   load;
    logic [3:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    out_ready = r;
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    load = !m_valid || r;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_start + k) % 4;
      if (w < 0 && v[idx]) w = idx;
    end
    exp_rdy = 4'b0000;
    if (load && w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    if (load) begin
      if (w >= 0) begin
        e.data = d[w*N +: N];
        e.src  = 2'(w);
        q.push_back(e);
        m_valid = 1'b1;
`ifdef ARB_BURST_EN
        if (w == m_start) m_run = m_run + 1;
        else m_run = 1;
        if (m_run >= MB) begin
          m_start = (w + 1) % 4;
          m_run   = 0;
        end else begin
          m_start = w;
        end
`else
        m_start = (w + 1) % 4;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: a new word appears after any edge where the output stage could load.
  initial begin
    bit         ld;
    bit         r0;
    exp_t       e;
    logic [N-1:0] last_data = '0;
    logic [1:0]   last_src  = 2'd0;
    forever begin
      @(negedge clk);
      #2;
      ld = !out_valid || out_ready;
      r0 = rst;
      @(posedge clk);
      #1;
      if (!rst && !r0) begin
        if (ld && out_valid) begin
          if (q.size() == 0) begin
            check("unexpected_word", {30'd0, out_src}, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("out_data", {24'd0, out_data}, {24'd0, e.data});
            check("out_src", {30'd0, out_src}, {30'd0, e.src});
            last_data = out_data;
            last_src  = out_src;
          end
        end else if (!ld) begin
          check("stall_data", {24'd0, out_data}, {24'd0, last_data});
          check("stall_src", {30'd0, out_src}, {30'd0, last_src});
        end
      end
    end
  end

  initial begin
    logic [3:0] rr_exp [6];
    logic [4*N-1:0] d;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    out_ready = 1'b1;
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_src", {30'd0, out_src}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;

    // All valid, continuous drain: rotating one-hot grants.
    for (int i = 0; i < 6; i++) begin
      run_cycle(4'b1111, 32'h1312_1110, 1'b1);
      check("rr_rotate", {28'd0, req_ready}, {28'd0, rr_exp[i]});
    end

    // Each mux leg alone.
    for (int i = 0; i < 4; i++) begin
      d = '0;
      d[i*N +: N] = 8'hA0 + 8'(i);
      run_cycle(4'b0001 << i, d, 1'b1);
      run_cycle(4'b0001 << i, d, 1'b1);
    end
    run_cycle(4'b0000, 32'h0, 1'b1);

    // Backpressure: load a word, stall 3 cycles, then release.
    run_cycle(4'b1111, 32'h2322_2120, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle(4'b1111, 32'h3332_3130, 1'b0);
    run_cycle(4'b1111, 32'h4342_4140, 1'b1);
    run_cycle(4'b1111, 32'h5352_5150, 1'b1);

    // Requester 2 alone, then 3 and 0 join.
    for (int i = 0; i < 3; i++) begin
      run_cycle(4'b0100, 32'h00C2_0000, 1'b1);
      check("only_req2", {28'd0, req_ready}, 32'd4);
    end
    run_cycle(4'b1101, 32'hD3C2_00D0, 1'b1);
`ifndef ARB_BURST_EN
    check("req3_after_2", {28'd0, req_ready}, 32'd8);
`endif
    run_cycle(4'b1101, 32'hD3C2_00D0, 1'b1);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_req_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    q.delete();
    m_start = 0;
    m_run   = 0;
    m_valid = 1'b0;
    run_cycle(4'b1111, 32'h6362_6160, 1'b1);
    check("first_after_rst", {28'd0, req_ready}, 32'd1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      run_cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end
    run_cycle(4'b0000, 32'h0, 1'b1);
    @(posedge clk);
    #2;
    check("queue_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux_4to1.md
Name: rr_arb_mux_4to1

Overview:
- Round-robin arbiter that shares one N-bit output channel among four requesters.
- Drives the select of a 4:1 N-bit data mux and registers the winning word into a one-entry output stage with a valid/ready handshake.
- Sits between four producer units and a single downstream consumer, for example a shared writeback or bus port.

Parameters:
- N, 8: data width per requester.
- MAX_BURST, 4: maximum consecutive grants to one requester. Used only when ARB_BURST_EN is defined; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  4  bit i: requester i presents a word.
- req_data  input  4*N  requester i word at bits [i*N +: N].
- req_ready  output  4  bit i: requester i word accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a word.
- out_data  output  N  registered winning word.
- out_src  output  2  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_src=0.
  - Priority pointer ptr=0; burst counter=0.
  - req_ready=0 while rst=1.
- Load condition: load = !out_valid || out_ready. The output register accepts a new word only when load=1.
- Arbitration (combinational, evaluated every cycle):
  - Scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Winner w = first index with req_valid set.
  - No winner: all req_ready=0.
- Grant:
  - req_ready[w] = load && any_valid. All other bits are 0.
  - req_ready must not depend on out_valid of the same requester, and has no combinational path from req_data.
- Mux mapping: select 0->requester 0, 1->requester 1, 2->requester 2, 3->requester 3. Exact index-to-slice correspondence is mandatory.
- On rising edge, with load=1 and a winner:
  - out_data <= req_data[w], out_src <= w, out_valid <= 1.
  - ptr <= (w+1) mod 4, using 2-bit wrap.
- On rising edge, with load=1 and no winner: out_valid <= 0. out_data and out_src hold their last value.
- On rising edge, with load=0 (out_valid=1, out_ready=0): out_valid, out_data, out_src and ptr all hold. No grant is issued.
- Timing:
  - Latency is 1 cycle from req_valid&&req_ready to out_valid.
  - Throughput is 1 word/cycle when out_ready=1 continuously.
- Fairness: a continuously valid requester is granted within 4 accept opportunities.
- Simultaneous drain and refill: out_valid && out_ready with a winner present produces back-to-back transfers with no bubble.
- Requesters may drop req_valid without a grant; the arbiter keeps no memory of it.
- Reset mid-transfer: the pending output word is discarded. After release, arbitration restarts with ptr=0.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - After a grant to w, ptr stays at w and burst counter increments.
  - ptr advances to (w+1) mod 4 and the counter clears when either the counter reaches MAX_BURST, or a grant goes to a different requester because w dropped req_valid.
  - Counter width is 4 bits.
- Undefined:
  - ptr advances after every grant as specified above.
  - No burst counter is instantiated, and MAX_BURST is ignored.

Test Plan:
- All four req_valid=1 with data 0x10,0x11,0x12,0x13; out_ready=1 -> out_src 0,1,2,3,0,1 on consecutive cycles, out_data matching index, req_ready one-hot rotating.
- Single requester per phase (only i valid, data 0xA0+i, i=0..3) -> out_data=0xA0+i, out_src=i. This checks every mux leg, including select 1 routing requester 1, not requester 3.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0 for 3 cycles with all requesters valid.
  - During stall: req_ready=0, out_data/out_src stable.
  - First cycle out_ready=1: a new grant goes to (previous out_src+1) mod 4, with out_valid continuous.
- Only requester 2 valid; out_ready=1 -> req_ready[2]=1 every cycle and out_src=2 each cycle. Then requesters 3 and 0 become valid -> requester 3 is granted first.
- Async reset: assert rst mid-stream between clock edges -> out_valid=0 and req_ready=0 before the next edge. After release with all valid, the first grant goes to requester 0.
- With ARB_BURST_EN, MAX_BURST=2, all valid, out_ready=1 -> out_src 0,0,1,1,2,2,3,3,0. Requester 1 dropping valid after one grant -> next grant goes to 2.
